// File: rtl/alu_exec_stage.sv
// Multi-cycle execute stage wrapped around an external combinational ALU; shift ops iterate the ALU in_count times.
// Optional build macro ALU_EXEC_STICKY_OVF_EN: overflow for shift ops becomes the OR over all iterations.
module alu_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [4:0]  in_op,
  input  logic [3:0]  in_count,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [15:0] alu_q,
  input  logic        alu_overflow,
  input  logic        alu_less,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_q,
  output logic [4:0]  flags
);

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 5;
  localparam int unsigned CW  = 4;
  localparam int unsigned FW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  opa_q, opa_d;
  logic [DW-1:0]  opb_q, opb_d;
  logic [OPW-1:0] opr_q, opr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bypass_q, bypass_d;
  logic [DW-1:0]  res_q, res_d;
  logic [FW-1:0]  flags_q, flags_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           ovf_sel;
`ifdef ALU_EXEC_STICKY_OVF_EN
  logic           ovf_acc_q, ovf_acc_d;
`endif

  // XOR shares the shift prefix but is a single-step op
  function automatic logic is_shift(input logic [OPW-1:0] op);
    return op[4] & op[3] & (op != 5'b11100);
  endfunction

  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_op    = opr_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_q     = res_q;
  assign flags     = flags_q;

`ifdef ALU_EXEC_STICKY_OVF_EN
  assign ovf_sel = is_shift(opr_q) ? (ovf_acc_q | alu_overflow) : alu_overflow;
`else
  assign ovf_sel = alu_overflow;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opr_d     = opr_q;
    cnt_d     = cnt_q;
    bypass_d  = bypass_q;
    res_d     = res_q;
    flags_d   = flags_q;
`ifdef ALU_EXEC_STICKY_OVF_EN
    ovf_acc_d = ovf_acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          opr_d   = in_op;
          state_d = EXEC;
          if (is_shift(in_op)) begin
            cnt_d    = in_count;
            bypass_d = (in_count == CW'(0));
          end else begin
            cnt_d    = CW'(1);
            bypass_d = 1'b0;
          end
`ifdef ALU_EXEC_STICKY_OVF_EN
          ovf_acc_d = 1'b0;
`endif
        end
      end
      EXEC: begin
        if (cnt_q != CW'(0)) begin
          opb_d = alu_q;
          cnt_d = cnt_q - CW'(1);
`ifdef ALU_EXEC_STICKY_OVF_EN
          ovf_acc_d = ovf_acc_q | alu_overflow;
`endif
          if (cnt_q == CW'(1)) begin
            res_d   = alu_q;
            flags_d = {ovf_sel, alu_less, alu_equal, alu_greater, alu_zero};
          end
        end else begin
          state_d = DONE;
          // Zero-count shift: operand B passes through, flags derived from it against zero
          if (bypass_q) begin
            res_d   = opb_q;
            flags_d = {1'b0, opb_q[DW-1], 1'b0,
                       ~opb_q[DW-1] & (opb_q != DW'(0)), opb_q == DW'(0)};
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      opr_q       <= '0;
      cnt_q       <= '0;
      bypass_q    <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_EXEC_STICKY_OVF_EN
      ovf_acc_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opr_q       <= opr_d;
      cnt_q       <= cnt_d;
      bypass_q    <= bypass_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_EXEC_STICKY_OVF_EN
      ovf_acc_q   <= ovf_acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with a small behavioural ALU attached to its alu_* ports.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [4:0]  in_op;
  logic [3:0]  in_count;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [15:0] alu_q;
  logic        alu_overflow, alu_less, alu_equal, alu_greater, alu_zero;
  logic        out_valid, out_ready;
  logic [15:0] out_q;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  alu_exec_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_count(in_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_q(alu_q), .alu_overflow(alu_overflow), .alu_less(alu_less),
    .alu_equal(alu_equal), .alu_greater(alu_greater), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .flags(flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD carry-out as overflow, shifts report the bit shifted out
  always_comb begin
    logic [16:0] sum;
    sum          = 17'(alu_a) + 17'(alu_b);
    alu_q        = alu_a & alu_b;
    alu_overflow = 1'b0;
    alu_less     = $signed(alu_a) <  $signed(alu_b);
    alu_equal    = alu_a == alu_b;
    alu_greater  = $signed(alu_a) >  $signed(alu_b);
    case (alu_op)
      5'b00001: begin alu_q = sum[15:0]; alu_overflow = sum[16]; end
      5'b01011: alu_q = alu_a - alu_b;
      5'b11000: begin alu_q = {1'b0, alu_b[15:1]};      alu_overflow = alu_b[0]; end
      5'b11010: begin alu_q = {alu_b[15], alu_b[15:1]}; alu_overflow = alu_b[0]; end
      5'b11100: alu_q = alu_a ^ alu_b;
      default:  alu_q = alu_a & alu_b;
    endcase
    alu_zero = (alu_q == 16'h0000);
  end

  // Offers one op, returns edges from accept to out_valid (-1 if never seen); leaves out_ready low
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] cnt, output int lat);
    int k;
    lat = -1;
    k   = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_count = cnt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic complete_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_q !== 16'h0000 || flags !== 5'b00000) begin failures++;
      $display("FAIL reset_result got q=%h f=%b exp q=0000 f=00000", out_q, flags); end
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 5'h0) begin failures++;
      $display("FAIL reset_alu_drive got a=%h b=%h op=%b exp zeros", alu_a, alu_b, alu_op); end
  endtask

  task automatic test_add();
    int lat;
    run_op(5'b00001, 16'hFFFF, 16'h0001, 4'd7, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (out_q !== 16'h0000) begin failures++; $display("FAIL add_q got=%h exp=0000", out_q); end
    checks++; if (flags[4] !== 1'b1 || flags[0] !== 1'b1) begin failures++;
      $display("FAIL add_ovf_zero got ovf=%b zero=%b exp 1 1", flags[4], flags[0]); end
    complete_op();
  endtask

  task automatic test_scmp();
    int lat;
    run_op(5'b01011, 16'h0001, 16'hFFFF, 4'd0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL scmp_latency got=%0d exp=2", lat); end
    checks++; if (flags !== 5'b00010) begin failures++; $display("FAIL scmp_flags got=%b exp=00010", flags); end
    complete_op();
  endtask

  task automatic test_xor_not_shift();
    int lat;
    run_op(5'b11100, 16'hA5A5, 16'h0FF0, 4'd0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL xor_latency got=%0d exp=2", lat); end
    checks++; if (out_q !== 16'hAA55) begin failures++; $display("FAIL xor_q got=%h exp=aa55", out_q); end
    complete_op();
  endtask

  task automatic test_shifts();
    int lat;
    run_op(5'b11000, 16'h0000, 16'h8001, 4'd4, lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL lrs_latency got=%0d exp=5", lat); end
    checks++; if (out_q !== 16'h0800) begin failures++; $display("FAIL lrs_q got=%h exp=0800", out_q); end
`ifdef ALU_EXEC_STICKY_OVF_EN
    checks++; if (flags[4] !== 1'b1) begin failures++; $display("FAIL lrs_ovf got=%b exp=1", flags[4]); end
`else
    checks++; if (flags[4] !== 1'b0) begin failures++; $display("FAIL lrs_ovf got=%b exp=0", flags[4]); end
`endif
    complete_op();
    run_op(5'b11010, 16'h0000, 16'h8000, 4'd3, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ars_latency got=%0d exp=4", lat); end
    checks++; if (out_q !== 16'hF000) begin failures++; $display("FAIL ars_q got=%h exp=f000", out_q); end
    complete_op();
    run_op(5'b11000, 16'h0000, 16'h0003, 4'd1, lat);
    checks++; if (lat !== 2 || out_q !== 16'h0001 || flags[4] !== 1'b1) begin failures++;
      $display("FAIL lrs1 got lat=%0d q=%h ovf=%b exp 2 0001 1", lat, out_q, flags[4]); end
    complete_op();
    run_op(5'b11000, 16'hFFFF, 16'h1234, 4'd0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL shift0_latency got=%0d exp=1", lat); end
    checks++; if (out_q !== 16'h1234 || flags[4] !== 1'b0 || flags[0] !== 1'b0) begin failures++;
      $display("FAIL shift0_result got q=%h ovf=%b zero=%b exp 1234 0 0", out_q, flags[4], flags[0]); end
    complete_op();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_op(5'b00001, 16'h0002, 16'h0003, 4'd0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_q !== 16'h0005 || flags !== 5'b01000 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0 (q=%h f=%b)", bad, out_q, flags); end
    // Offer a new op in the handshake cycle; it must not be taken
    out_ready = 1'b1; in_valid = 1'b1; in_op = 5'b00001; in_a = 16'h1111; in_b = 16'h1111; in_count = 4'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL bp_after got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
    checks++; if (out_q !== 16'h0005 || alu_a !== 16'h0002) begin failures++;
      $display("FAIL bp_retain got q=%h alu_a=%h exp 0005 0002", out_q, alu_a); end
  endtask

  task automatic test_reset_midshift();
    int seen;
    in_valid = 1'b1; in_op = 5'b11000; in_a = 16'h0; in_b = 16'hFFFF; in_count = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL midrst_state got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
    checks++; if (out_q !== 16'h0000 || flags !== 5'b00000) begin failures++;
      $display("FAIL midrst_result got q=%h f=%b exp 0000 00000", out_q, flags); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_count = '0;
    test_reset();
    test_add();
    test_scmp();
    test_xor_not_shift();
    test_shifts();
    test_backpressure();
    test_reset_midshift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
